slice_interleave_mux: RTL and testbench

Parametrised successor of the decoder's slice output multiplexer. Drains per-slice show-ahead pixel FIFOs, already in the output clock domain, in raster order: chunk of slice 0, slice 1, … slice N-1, then the next line. Emits one beat of PIXS_PER_BEAT pixels per cycle with a per-pixel valid mask, sof/eol/eof flags and ready/valid backpressure. Slice width, slice count and frame height are runtime configuration latched at frame start; the last-beat mask is derived internally from slice_width, not supplied externally.

---
 rtl/slice_mux_pkg.sv | 28 ++
 rtl/slice_raster_ctr.sv | 78 +++++++
 rtl/slice_interleave_mux.sv | 187 ++++++++++++++++++
 tb/tb_slice_interleave_mux.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slice_mux_pkg.sv
// Shared definitions for the slice interleave multiplexer:
//   - pixel / beat width helpers
//   - top-level FSM state encoding
//   - partial-beat pixel mask helper
package slice_mux_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int unsigned pix_w(input int unsigned ncomp, input int unsigned bpc);
    return ncomp * bpc;
  endfunction

  function automatic int unsigned beat_w(input int unsigned pixs, input int unsigned pixw);
    return pixs * pixw;
  endfunction

  // LSB-aligned mask with n ones (n = 1..8); callers truncate to their beat size.
  function automatic logic [7:0] tail_mask(input logic [3:0] n);
    logic [8:0] t;
    t = (9'd1 << n) - 9'd1;
    return t[7:0];
  endfunction

endpackage

// File: rtl/slice_raster_ctr.sv
// Raster position counters for the slice interleave multiplexer.
// Tracks beat-within-chunk, selected slice and line, advancing once per load.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   clr_i                  zero all counters (frame start / abort)
//   ld_i                   a beat is loaded this cycle; advance position
//   beats_per_chunk_i      latched chunk length in beats (>=1)
//   slices_per_line_i      latched slice count (>=1)
//   frame_height_i         latched line count (>=1)
//   sel_o                  slice currently being drained
//   first_beat_o           position is line 0, slice 0, beat 0
//   last_beat_o            position is the last beat of a chunk
//   last_slice_o           position is in the last slice of the line
//   last_line_o            position is in the last line of the frame
module slice_raster_ctr #(
  parameter int unsigned SEL_W  = 4,
  parameter int unsigned BCNT_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              ld_i,
  input  logic [BCNT_W-1:0] beats_per_chunk_i,
  input  logic [SEL_W-1:0]  slices_per_line_i,
  input  logic [15:0]       frame_height_i,
  output logic [SEL_W-1:0]  sel_o,
  output logic              first_beat_o,
  output logic              last_beat_o,
  output logic              last_slice_o,
  output logic              last_line_o
);

  logic [BCNT_W-1:0] beat_q, beat_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [15:0]       line_q, line_d;

  assign first_beat_o = (beat_q == '0) && (sel_q == '0) && (line_q == '0);
  assign last_beat_o  = (beat_q == beats_per_chunk_i - BCNT_W'(1));
  assign last_slice_o = (sel_q == slices_per_line_i - SEL_W'(1));
  assign last_line_o  = (line_q == frame_height_i - 16'd1);
  assign sel_o        = sel_q;

  always_comb begin
    beat_d = beat_q;
    sel_d  = sel_q;
    line_d = line_q;
    if (clr_i) begin
      beat_d = '0;
      sel_d  = '0;
      line_d = '0;
    end else if (ld_i) begin
      if (last_beat_o) begin
        beat_d = '0;
        if (last_slice_o) begin
          sel_d  = '0;
          line_d = line_q + 16'd1;
        end else begin
          sel_d = sel_q + SEL_W'(1);
        end
      end else begin
        beat_d = beat_q + BCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q <= '0;
      sel_q  <= '0;
      line_q <= '0;
    end else begin
      beat_q <= beat_d;
      sel_q  <= sel_d;
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/slice_interleave_mux.sv
// Slice interleave multiplexer: drains per-slice show-ahead FIFOs in raster
// order (chunk of slice 0 .. slice N-1, then next line) into a registered
// ready/valid beat stream with pixel mask and sof/eol/eof flags.
// Ports:
//   clk_out_int, rst_n          output pixel clock, async active-low reset
//   frame_start                 latch config, abort current frame, start new one
//   slices_per_line, slice_width, frame_height   runtime geometry
//   fifo_data, fifo_valid       per-slice FIFO head word / non-empty
//   fifo_rd_en                  per-slice pop strobe (combinational)
//   pixs_out, pixs_out_mask, pixs_out_valid, pixs_out_ready   output beat
//   pixs_out_sof/eol/eof        frame / line boundary flags
//   busy                        frame in progress
//   cfg_err                     last frame_start carried an illegal config
module slice_interleave_mux
  import slice_mux_pkg::*;
#(
  parameter  int unsigned MAX_NBR_SLICES  = 8,
  parameter  int unsigned MAX_SLICE_WIDTH = 2560,
  parameter  int unsigned PIXS_PER_BEAT   = 4,
  parameter  int unsigned NCOMP           = 3,
  parameter  int unsigned BPC             = 14,
  localparam int unsigned PIX_W           = pix_w(NCOMP, BPC),
  localparam int unsigned BEAT_W          = beat_w(PIXS_PER_BEAT, PIX_W),
  localparam int unsigned SPL_W           = $clog2(MAX_NBR_SLICES + 1),
  localparam int unsigned SW_W            = $clog2(MAX_SLICE_WIDTH + 1)
) (
  input  logic                             clk_out_int,
  input  logic                             rst_n,
  input  logic                             frame_start,
  input  logic [SPL_W-1:0]                 slices_per_line,
  input  logic [SW_W-1:0]                  slice_width,
  input  logic [15:0]                      frame_height,
  input  logic [MAX_NBR_SLICES*BEAT_W-1:0] fifo_data,
  input  logic [MAX_NBR_SLICES-1:0]        fifo_valid,
  output logic [MAX_NBR_SLICES-1:0]        fifo_rd_en,
  output logic [BEAT_W-1:0]                pixs_out,
  output logic [PIXS_PER_BEAT-1:0]         pixs_out_mask,
  output logic                             pixs_out_valid,
  input  logic                             pixs_out_ready,
  output logic                             pixs_out_sof,
  output logic                             pixs_out_eol,
  output logic                             pixs_out_eof,
  output logic                             busy,
  output logic                             cfg_err
);

  localparam int unsigned LC_W = $clog2(PIXS_PER_BEAT + 1);

  state_e state_q, state_d;

  // Latched geometry
  logic [SPL_W-1:0] spl_q;
  logic [SW_W-1:0]  bpc_q, bpc_d;
  logic [LC_W-1:0]  last_cnt_q, last_cnt_d;
  logic [15:0]      fh_q;
  logic             cfg_ok;

  logic [SW_W:0]    sw_round;
  logic [SW_W-1:0]  sw_m1;

  logic [SPL_W-1:0] sel;
  logic             first_beat, last_beat, last_slice, last_line;
  logic             sel_valid, ld;
  logic [BEAT_W-1:0] sel_data;

  logic [BEAT_W-1:0]        data_q;
  logic [PIXS_PER_BEAT-1:0] mask_q, mask_d;
  logic                     valid_q, sof_q, eol_q, eof_q;
  logic                     eol_d, eof_d;

  assign cfg_ok = (slices_per_line != '0) && (slices_per_line <= SPL_W'(MAX_NBR_SLICES)) &&
                  (slice_width != '0) && (slice_width <= SW_W'(MAX_SLICE_WIDTH)) &&
                  (frame_height != 16'd0);

  // ceil(width/P); last_cnt = ((width-1) mod P) + 1 equals width-(bpc-1)*P
  assign sw_round   = ({1'b0, slice_width} + (SW_W+1)'(PIXS_PER_BEAT - 1)) / (SW_W+1)'(PIXS_PER_BEAT);
  assign bpc_d      = sw_round[SW_W-1:0];
  assign sw_m1      = slice_width - SW_W'(1);
  assign last_cnt_d = LC_W'(sw_m1 % SW_W'(PIXS_PER_BEAT)) + LC_W'(1);

  always_ff @(posedge clk_out_int or negedge rst_n) begin
    if (!rst_n) begin
      spl_q      <= '0;
      bpc_q      <= '0;
      last_cnt_q <= '0;
      fh_q       <= '0;
    end else if (frame_start) begin
      spl_q      <= slices_per_line;
      bpc_q      <= bpc_d;
      last_cnt_q <= last_cnt_d;
      fh_q       <= frame_height;
    end
  end

  slice_raster_ctr #(
    .SEL_W  (SPL_W),
    .BCNT_W (SW_W)
  ) u_ctr (
    .clk_i             (clk_out_int),
    .rst_ni            (rst_n),
    .clr_i             (frame_start),
    .ld_i              (ld),
    .beats_per_chunk_i (bpc_q),
    .slices_per_line_i (spl_q),
    .frame_height_i    (fh_q),
    .sel_o             (sel),
    .first_beat_o      (first_beat),
    .last_beat_o       (last_beat),
    .last_slice_o      (last_slice),
    .last_line_o       (last_line)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int unsigned s = 0; s < MAX_NBR_SLICES; s++) begin
      if (sel == SPL_W'(s)) begin
        sel_valid = fifo_valid[s];
        sel_data  = fifo_data[s*BEAT_W +: BEAT_W];
      end
    end
  end

  // A frame_start cycle never pops: the old frame is being abandoned.
  assign ld = (state_q == S_RUN) && !frame_start && sel_valid && (!valid_q || pixs_out_ready);

  always_comb begin
    fifo_rd_en = '0;
    for (int unsigned s = 0; s < MAX_NBR_SLICES; s++) begin
      fifo_rd_en[s] = ld && (sel == SPL_W'(s));
    end
  end

  assign mask_d = last_beat ? PIXS_PER_BEAT'(tail_mask(4'(last_cnt_q))) : '1;
  assign eol_d  = last_beat && last_slice;
  assign eof_d  = eol_d && last_line;

  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = cfg_ok ? S_RUN : S_IDLE;
    end else if (ld && eof_d) begin
      state_d = S_DONE;
    end
  end

  always_ff @(posedge clk_out_int or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cfg_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (frame_start) cfg_err <= !cfg_ok;
    end
  end

  always_ff @(posedge clk_out_int or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else if (frame_start) begin
      valid_q <= 1'b0;
    end else if (ld) begin
      data_q  <= sel_data;
      mask_q  <= mask_d;
      valid_q <= 1'b1;
      sof_q   <= first_beat;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
    end else if (pixs_out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign pixs_out       = data_q;
  assign pixs_out_mask  = mask_q;
  assign pixs_out_valid = valid_q;
  assign pixs_out_sof   = sof_q;
  assign pixs_out_eol   = eol_q;
  assign pixs_out_eof   = eof_q;
  assign busy           = (state_q == S_RUN);

endmodule

// File: tb/tb_slice_interleave_mux.sv
module tb_slice_interleave_mux;

  localparam int unsigned MAXS   = 8;
  localparam int unsigned MAXW   = 2560;
  localparam int unsigned P      = 4;
  localparam int unsigned PIX_W  = 3 * 14;
  localparam int unsigned BEAT_W = P * PIX_W;
  localparam int unsigned SPL_W  = $clog2(MAXS + 1);
  localparam int unsigned SW_W   = $clog2(MAXW + 1);

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     frame_start;
  logic [SPL_W-1:0]         slices_per_line;
  logic [SW_W-1:0]          slice_width;
  logic [15:0]              frame_height;
  logic [MAXS*BEAT_W-1:0]   fifo_data;
  logic [MAXS-1:0]          fifo_valid;
  logic [MAXS-1:0]          fifo_rd_en;
  logic [BEAT_W-1:0]        pixs_out;
  logic [P-1:0]             pixs_out_mask;
  logic                     pixs_out_valid, pixs_out_ready;
  logic                     pixs_out_sof, pixs_out_eol, pixs_out_eof;
  logic                     busy, cfg_err;

  always #5 clk = ~clk;

  slice_interleave_mux #(
    .MAX_NBR_SLICES  (MAXS),
    .MAX_SLICE_WIDTH (MAXW),
    .PIXS_PER_BEAT   (P),
    .NCOMP           (3),
    .BPC             (14)
  ) dut (
    .clk_out_int     (clk),
    .rst_n           (rst_n),
    .frame_start     (frame_start),
    .slices_per_line (slices_per_line),
    .slice_width     (slice_width),
    .frame_height    (frame_height),
    .fifo_data       (fifo_data),
    .fifo_valid      (fifo_valid),
    .fifo_rd_en      (fifo_rd_en),
    .pixs_out        (pixs_out),
    .pixs_out_mask   (pixs_out_mask),
    .pixs_out_valid  (pixs_out_valid),
    .pixs_out_ready  (pixs_out_ready),
    .pixs_out_sof    (pixs_out_sof),
    .pixs_out_eol    (pixs_out_eol),
    .pixs_out_eof    (pixs_out_eof),
    .busy            (busy),
    .cfg_err         (cfg_err)
  );

  typedef struct {
    logic [BEAT_W-1:0] d;
    logic [P-1:0]      m;
    logic              sof, eol, eof;
  } beat_t;

  beat_t             exp_q[$];
  int unsigned       pop_q[$];
  logic [BEAT_W-1:0] fq[MAXS][$];

  int unsigned n_chk = 0, n_pass = 0;
  int unsigned n_pop, n_acc;
  int          stall_slice = -1;
  int unsigned stall_left  = 0;
  logic        hold_prev   = 1'b0;
  logic [BEAT_W+P+2:0] prev_out;

  function automatic logic [BEAT_W-1:0] rand_word();
    logic [191:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return w[BEAT_W-1:0];
  endfunction

  // One clock: drive FIFO heads, observe, apply pops/accepts to the model.
  task automatic step();
    logic [MAXS-1:0]     rd;
    logic                acc;
    logic [BEAT_W+P+2:0] cur, want;
    beat_t               e;
    for (int s = 0; s < int'(MAXS); s++) begin
      fifo_valid[s] = (fq[s].size() > 0) && !(s == stall_slice && stall_left > 0);
      fifo_data[s*BEAT_W +: BEAT_W] = (fq[s].size() > 0) ? fq[s][0] : '0;
    end
    #1;
    rd  = fifo_rd_en;
    acc = pixs_out_valid && pixs_out_ready;
    cur = {pixs_out, pixs_out_mask, pixs_out_sof, pixs_out_eol, pixs_out_eof};
    if (hold_prev) begin
      n_chk++;
      if (cur !== prev_out || pixs_out_valid !== 1'b1)
        $display("FAIL hold: outputs changed while stalled, got %h want %h", cur, prev_out);
      else n_pass++;
    end
    if (acc) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL extra_beat: unexpected beat %h, want none", cur);
      end else begin
        e    = exp_q.pop_front();
        want = {e.d, e.m, e.sof, e.eol, e.eof};
        if (cur !== want)
          $display("FAIL beat%0d: got mask/sof/eol/eof %b/%b%b%b data %h, want %b/%b%b%b data %h",
                   n_acc, pixs_out_mask, pixs_out_sof, pixs_out_eol, pixs_out_eof, pixs_out,
                   e.m, e.sof, e.eol, e.eof, e.d);
        else n_pass++;
      end
      n_acc++;
    end
    for (int s = 0; s < int'(MAXS); s++) begin
      if (rd[s]) begin
        n_chk++;
        if (pop_q.size() == 0 || pop_q[0] != s || !fifo_valid[s])
          $display("FAIL pop: popped slice %0d (valid %b), want slice %0d",
                   s, fifo_valid[s], (pop_q.size() > 0) ? int'(pop_q[0]) : -1);
        else n_pass++;
        if (pop_q.size() > 0) void'(pop_q.pop_front());
        if (fq[s].size() > 0) void'(fq[s].pop_front());
        n_pop++;
      end
    end
    hold_prev = pixs_out_valid && !pixs_out_ready;
    prev_out  = cur;
    if (stall_left > 0) stall_left--;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pulse frame_start, then rebuild the FIFO contents and expected stream.
  task automatic start_frame(input int n, input int sw, input int h, input bit legal);
    int bpc, rem;
    beat_t b;
    hold_prev       = 1'b0;
    frame_start     = 1'b1;
    slices_per_line = SPL_W'(n);
    slice_width     = SW_W'(sw);
    frame_height    = 16'(h);
    step();
    frame_start = 1'b0;
    hold_prev   = 1'b0;
    n_chk++;
    if (pixs_out_valid !== 1'b0) $display("FAIL abort_valid: valid %b, want 0", pixs_out_valid);
    else n_pass++;
    for (int s = 0; s < int'(MAXS); s++) fq[s].delete();
    exp_q.delete();
    pop_q.delete();
    n_pop = 0;
    n_acc = 0;
    if (legal) begin
      bpc = (sw + int'(P) - 1) / int'(P);
      for (int l = 0; l < h; l++)
        for (int s = 0; s < n; s++)
          for (int k = 0; k < bpc; k++) begin
            b.d   = rand_word();
            rem   = sw - k * int'(P);
            b.m   = (rem >= int'(P)) ? '1 : P'((1 << rem) - 1);
            b.sof = (l == 0) && (s == 0) && (k == 0);
            b.eol = (k == bpc - 1) && (s == n - 1);
            b.eof = b.eol && (l == h - 1);
            fq[s].push_back(b.d);
            exp_q.push_back(b);
            pop_q.push_back(s);
          end
    end
  endtask

  task automatic drain(input int pct, input int stop_after, output int cyc);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 3000 && (stop_after == 0 || n_acc < stop_after)) begin
      pixs_out_ready = ($urandom_range(0, 99) < pct);
      step();
      cyc++;
    end
    if (cyc >= 3000) begin
      n_chk++;
      $display("FAIL timeout: %0d beats outstanding, want 0", exp_q.size());
    end
  endtask

  // After the eof beat: idle, pop count balanced, further FIFO data ignored.
  task automatic finish_frame();
    n_chk++;
    if (busy !== 1'b0) $display("FAIL done_busy: busy %b, want 0", busy);
    else n_pass++;
    n_chk++;
    if (n_pop != n_acc) $display("FAIL pop_count: pops %0d, want %0d", n_pop, n_acc);
    else n_pass++;
    fq[0].push_back(rand_word());
    pixs_out_ready = 1'b1;
    repeat (3) step();
    n_chk++;
    if (pixs_out_valid !== 1'b0 || fifo_rd_en !== '0)
      $display("FAIL done_idle: valid %b rd_en %b, want 0 0", pixs_out_valid, fifo_rd_en);
    else n_pass++;
  endtask

  task automatic test_reset();
    fifo_valid = '1;
    #1;
    n_chk++;
    if ({pixs_out_valid, pixs_out_mask, pixs_out_sof, pixs_out_eol, pixs_out_eof, busy, cfg_err} !== '0)
      $display("FAIL reset_flags: got %b, want 0", {pixs_out_valid, pixs_out_mask, pixs_out_sof,
               pixs_out_eol, pixs_out_eof, busy, cfg_err});
    else n_pass++;
    n_chk++;
    if (pixs_out !== '0 || fifo_rd_en !== '0)
      $display("FAIL reset_data: pixs_out %h rd_en %b, want 0", pixs_out, fifo_rd_en);
    else n_pass++;
    fifo_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc;
    start_frame(2, 16, 2, 1'b1);
    n_chk++;
    if (busy !== 1'b1 || cfg_err !== 1'b0)
      $display("FAIL basic_start: busy %b cfg_err %b, want 1 0", busy, cfg_err);
    else n_pass++;
    drain(100, 0, cyc);
    n_chk++;
    if (cyc != 17) $display("FAIL throughput: %0d cycles, want 17", cyc);
    else n_pass++;
    finish_frame();
  endtask

  task automatic test_partial();
    int cyc;
    start_frame(2, 13, 2, 1'b1);
    drain(100, 0, cyc);
    finish_frame();
  endtask

  task automatic test_random_ready();
    int cyc;
    start_frame(3, 10, 3, 1'b1);
    drain(50, 0, cyc);
    finish_frame();
  endtask

  task automatic test_stall();
    int cyc;
    start_frame(2, 16, 2, 1'b1);
    stall_slice    = 1;
    stall_left     = 10;
    pixs_out_ready = 1'b1;
    repeat (10) step();
    n_chk++;
    if (pixs_out_valid !== 1'b0) $display("FAIL stall_valid: valid %b, want 0", pixs_out_valid);
    else n_pass++;
    stall_slice = -1;
    drain(100, 0, cyc);
    finish_frame();
  endtask

  task automatic test_abort();
    int cyc;
    start_frame(2, 16, 2, 1'b1);
    drain(100, 5, cyc);
    start_frame(2, 8, 1, 1'b1);
    drain(100, 0, cyc);
    finish_frame();
  endtask

  task automatic test_cfg_err();
    int cfgs[5][3] = '{'{0, 16, 1}, '{9, 16, 1}, '{2, 0, 1}, '{2, 2561, 1}, '{2, 16, 0}};
    for (int i = 0; i < 5; i++) begin
      start_frame(cfgs[i][0], cfgs[i][1], cfgs[i][2], 1'b0);
      n_chk++;
      if (cfg_err !== 1'b1 || busy !== 1'b0)
        $display("FAIL cfg_err%0d: cfg_err %b busy %b, want 1 0", i, cfg_err, busy);
      else n_pass++;
      fq[0].push_back(rand_word());
      fq[1].push_back(rand_word());
      pixs_out_ready = 1'b1;
      repeat (3) step();
    end
  endtask

  task automatic test_random();
    int cyc, n, sw, h;
    for (int i = 0; i < 8; i++) begin
      n  = (i == 0) ? 1 : int'($urandom_range(1, 4));
      sw = (i == 0) ? 3 : int'($urandom_range(1, 20));
      h  = int'($urandom_range(1, 3));
      start_frame(n, sw, h, 1'b1);
      drain(int'($urandom_range(30, 100)), 0, cyc);
      finish_frame();
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    frame_start     = 1'b0;
    slices_per_line = '0;
    slice_width     = '0;
    frame_height    = '0;
    fifo_data       = '0;
    fifo_valid      = '0;
    pixs_out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_partial();
    test_random_ready();
    test_stall();
    test_abort();
    test_cfg_err();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
